// File: rtl/temporizador_jogada_if.sv
// temporizador_jogada_if
// Groups the control and status signals of the move timer.
//   master : drives tick, iniciar, pausar, parar, limite; reads status
//   slave  : the timer itself; reads controls, drives contagem, restante,
//            ativo, pausado, timeout, expirado
interface temporizador_jogada_if #(
    parameter int N = 8
) ();
    logic         tick;
    logic         iniciar;
    logic         pausar;
    logic         parar;
    logic [N-1:0] limite;
    logic [N-1:0] contagem;
    logic [N-1:0] restante;
    logic         ativo;
    logic         pausado;
    logic         timeout;
    logic         expirado;

    modport master (
        output tick, iniciar, pausar, parar, limite,
        input  contagem, restante, ativo, pausado, timeout, expirado
    );

    modport slave (
        input  tick, iniciar, pausar, parar, limite,
        output contagem, restante, ativo, pausado, timeout, expirado
    );
endinterface

// File: rtl/temporizador_jogada.sv
// temporizador_jogada
// Counts prescaler ticks up to a limit captured at start and flags a
// timeout when the limit is reached (per-move time limit of the game).
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of temporizador_jogada_if
//           in : tick, iniciar (start/restart), pausar (level), parar (abort),
//                limite (sampled on iniciar)
//           out: contagem, restante (= limite_reg - contagem), ativo, pausado,
//                timeout (one-cycle pulse), expirado (level)
// Input priority every cycle: parar > iniciar > pausar > tick.
module temporizador_jogada #(
    parameter int N                   = 8,
    parameter int ESPERA_TICK_INICIAL = 0
) (
    input logic                  clock,
    input logic                  reset,
    temporizador_jogada_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO,
        CONTANDO,
        PAUSADO,
        ESGOTADO
    } estado_t;

    estado_t      estado;
    logic [N-1:0] limite_reg;
    logic [N-1:0] contagem;
    logic         pular_tick;
    logic         ativo;
    logic         pausado;
    logic         timeout;
    logic         expirado;

    // While counting, contagem < limite_reg <= 2^N-1, so the increment
    // never wraps and the equality test detects the final tick exactly.
    logic [N-1:0] contagem_mais_um;
    assign contagem_mais_um = contagem + N'(1);

    // Single state machine; status flags are registered together with the
    // state so they always agree with it. timeout defaults low each cycle,
    // which guarantees a single-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            limite_reg <= '0;
            contagem   <= '0;
            pular_tick <= 1'b0;
            ativo      <= 1'b0;
            pausado    <= 1'b0;
            timeout    <= 1'b0;
            expirado   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (bus.parar) begin
                // Abort keeps limite_reg so restante shows the full limit.
                estado   <= OCIOSO;
                contagem <= '0;
                ativo    <= 1'b0;
                pausado  <= 1'b0;
                expirado <= 1'b0;
            end else if (bus.iniciar) begin
                limite_reg <= bus.limite;
                contagem   <= '0;
                pular_tick <= (ESPERA_TICK_INICIAL != 0);
                pausado    <= 1'b0;
                if (bus.limite == '0) begin
                    // A zero limit expires immediately.
                    estado   <= ESGOTADO;
                    timeout  <= 1'b1;
                    expirado <= 1'b1;
                    ativo    <= 1'b0;
                end else begin
                    estado   <= CONTANDO;
                    expirado <= 1'b0;
                    ativo    <= 1'b1;
                end
            end else begin
                case (estado)
                    CONTANDO: begin
                        if (bus.pausar) begin
                            estado  <= PAUSADO;
                            pausado <= 1'b1;
                        end else if (bus.tick) begin
                            if (pular_tick) begin
                                // First tick after start may be a partial period.
                                pular_tick <= 1'b0;
                            end else begin
                                contagem <= contagem_mais_um;
                                if (contagem_mais_um == limite_reg) begin
                                    estado   <= ESGOTADO;
                                    timeout  <= 1'b1;
                                    expirado <= 1'b1;
                                    ativo    <= 1'b0;
                                end
                            end
                        end
                    end
                    PAUSADO: begin
                        // A tick in the release cycle is dropped on purpose.
                        if (!bus.pausar) begin
                            estado  <= CONTANDO;
                            pausado <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.contagem = contagem;
    assign bus.restante = limite_reg - contagem;
    assign bus.ativo    = ativo;
    assign bus.pausado  = pausado;
    assign bus.timeout  = timeout;
    assign bus.expirado = expirado;

endmodule

// File: tb/tb_temporizador_jogada.sv
// tb_temporizador_jogada
// Table-driven check of temporizador_jogada (N=8) plus hand-written
// sequences for asynchronous reset, the 255 limit and the skip-first-tick
// build (second instance with ESPERA_TICK_INICIAL=1).
module tb_temporizador_jogada;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       iniciar;
    logic       pausar;
    logic       parar;
    logic [7:0] limite;

    int total;
    int bad;

    temporizador_jogada_if #(.N(8)) bus0 ();
    temporizador_jogada_if #(.N(8)) bus1 ();

    assign bus0.tick    = tick;
    assign bus0.iniciar = iniciar;
    assign bus0.pausar  = pausar;
    assign bus0.parar   = parar;
    assign bus0.limite  = limite;
    assign bus1.tick    = tick;
    assign bus1.iniciar = iniciar;
    assign bus1.pausar  = pausar;
    assign bus1.parar   = parar;
    assign bus1.limite  = limite;

    temporizador_jogada #(.N(8), .ESPERA_TICK_INICIAL(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    temporizador_jogada #(.N(8), .ESPERA_TICK_INICIAL(1)) dut_skip (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       tk;
        logic       ini;
        logic       pau;
        logic       par;
        logic [7:0] lim;
        int         rep;
        logic [7:0] e_cnt;
        logic [7:0] e_rest;
        logic       e_ativo;
        logic       e_pausado;
        logic       e_to;
        logic       e_exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic tk, logic ini, logic pau, logic par,
                                logic [7:0] lim, int rep,
                                logic [7:0] c, logic [7:0] r, logic a,
                                logic p, logic to, logic ex);
        vec_t v;
        v = '{tk, ini, pau, par, lim, rep, c, r, a, p, to, ex};
        vecs.push_back(v);
    endfunction

    task automatic checkOne(string name, int act, int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic checkOutput(string name, logic [7:0] c, logic [7:0] r,
                               logic a, logic p, logic to, logic ex);
        checkOne({name, ".contagem"}, int'(bus0.contagem), int'(c));
        checkOne({name, ".restante"}, int'(bus0.restante), int'(r));
        checkOne({name, ".ativo"},    int'(bus0.ativo),    int'(a));
        checkOne({name, ".pausado"},  int'(bus0.pausado),  int'(p));
        checkOne({name, ".timeout"},  int'(bus0.timeout),  int'(to));
        checkOne({name, ".expirado"}, int'(bus0.expirado), int'(ex));
    endtask

    // Inputs are held for one clock; outputs are sampled 1 time unit after it.
    task automatic applyStimulus(logic tk, logic ini, logic pau, logic par,
                                 logic [7:0] lim);
        tick    = tk;
        iniciar = ini;
        pausar  = pau;
        parar   = par;
        limite  = lim;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        tick    = 1'b0;
        iniciar = 1'b0;
        pausar  = 1'b0;
        parar   = 1'b0;
        limite  = 8'd0;
        #12;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("reset_state", 8'd0, 8'd0, 0, 0, 0, 0);

        // Normal expiry, limite=3, ticks 10 cycles apart
        add(0,1,0,0, 8'd3, 1, 8'd0, 8'd3, 1,0,0,0);
        add(0,0,0,0, 8'd3, 9, 8'd0, 8'd3, 1,0,0,0);
        add(1,0,0,0, 8'd3, 1, 8'd1, 8'd2, 1,0,0,0);
        add(0,0,0,0, 8'd3, 9, 8'd1, 8'd2, 1,0,0,0);
        add(1,0,0,0, 8'd3, 1, 8'd2, 8'd1, 1,0,0,0);
        add(0,0,0,0, 8'd3, 9, 8'd2, 8'd1, 1,0,0,0);
        add(1,0,0,0, 8'd3, 1, 8'd3, 8'd0, 0,0,1,1);
        add(0,0,0,0, 8'd3, 1, 8'd3, 8'd0, 0,0,0,1);
        add(1,0,1,0, 8'd3, 3, 8'd3, 8'd0, 0,0,0,1);
        // Pause boundaries, limite=4
        add(0,1,0,0, 8'd4, 1, 8'd0, 8'd4, 1,0,0,0);
        add(1,0,0,0, 8'd4, 2, 8'd2, 8'd2, 1,0,0,0);
        add(1,0,1,0, 8'd4, 1, 8'd2, 8'd2, 1,1,0,0);
        add(1,0,1,0, 8'd4, 5, 8'd2, 8'd2, 1,1,0,0);
        add(1,0,0,0, 8'd4, 1, 8'd2, 8'd2, 1,0,0,0);
        add(1,0,0,0, 8'd4, 1, 8'd3, 8'd1, 1,0,0,0);
        add(1,0,0,0, 8'd4, 1, 8'd4, 8'd0, 0,0,1,1);
        add(0,0,0,0, 8'd7, 2, 8'd4, 8'd0, 0,0,0,1);
        // Priority: parar wins over iniciar and tick; limite_reg held
        add(0,1,0,0, 8'd5, 1, 8'd0, 8'd5, 1,0,0,0);
        add(1,0,0,0, 8'd5, 2, 8'd2, 8'd3, 1,0,0,0);
        add(1,1,0,1, 8'd9, 1, 8'd0, 8'd5, 0,0,0,0);
        add(1,0,1,0, 8'd9, 2, 8'd0, 8'd5, 0,0,0,0);
        // Restart from ESGOTADO
        add(0,1,0,0, 8'd1, 1, 8'd0, 8'd1, 1,0,0,0);
        add(1,0,0,0, 8'd1, 1, 8'd1, 8'd0, 0,0,1,1);
        add(1,1,0,0, 8'd2, 1, 8'd0, 8'd2, 1,0,0,0);
        add(1,0,0,0, 8'd2, 1, 8'd1, 8'd1, 1,0,0,0);
        // iniciar takes priority over pausar
        add(0,1,1,0, 8'd6, 1, 8'd0, 8'd6, 1,0,0,0);
        add(0,0,1,0, 8'd6, 1, 8'd0, 8'd6, 1,1,0,0);
        // Zero limit expires immediately, then abort
        add(0,1,0,0, 8'd0, 1, 8'd0, 8'd0, 0,0,1,1);
        add(1,0,0,0, 8'd0, 1, 8'd0, 8'd0, 0,0,0,1);
        add(0,0,0,1, 8'd0, 1, 8'd0, 8'd0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].rep; k++)
                applyStimulus(vecs[i].tk, vecs[i].ini, vecs[i].pau,
                              vecs[i].par, vecs[i].lim);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_rest,
                        vecs[i].e_ativo, vecs[i].e_pausado, vecs[i].e_to,
                        vecs[i].e_exp);
        end

        // Asynchronous reset in the middle of a count
        applyStimulus(0, 1, 0, 0, 8'd5);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 8'd5);
        checkOutput("pre_reset", 8'd3, 8'd2, 1, 0, 0, 0);
        tick = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 8'd0, 8'd0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'd5);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 8'd5);
        checkOutput("after_reset", 8'd0, 8'd0, 0, 0, 0, 0);

        // Full-scale limit: timeout only on the 255th tick, no wrap
        applyStimulus(0, 1, 0, 0, 8'd255);
        for (int k = 0; k < 254; k++) applyStimulus(1, 0, 0, 0, 8'd255);
        checkOutput("lim255_t254", 8'd254, 8'd1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'd255);
        checkOutput("lim255_t255", 8'd255, 8'd0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 8'd255);
        checkOutput("lim255_after", 8'd255, 8'd0, 0, 0, 0, 1);

        // Skip-first-tick build, limite=2
        applyStimulus(0, 1, 0, 0, 8'd2);
        applyStimulus(1, 0, 0, 0, 8'd2);
        checkOne("skip_t1.contagem", int'(bus1.contagem), 0);
        checkOne("skip_t1.ativo",    int'(bus1.ativo),    1);
        applyStimulus(1, 0, 0, 0, 8'd2);
        checkOne("skip_t2.contagem", int'(bus1.contagem), 1);
        checkOne("skip_t2.timeout",  int'(bus1.timeout),  0);
        applyStimulus(1, 0, 0, 0, 8'd2);
        checkOne("skip_t3.contagem", int'(bus1.contagem), 2);
        checkOne("skip_t3.timeout",  int'(bus1.timeout),  1);
        checkOne("skip_t3.expirado", int'(bus1.expirado), 1);
        checkOne("skip_t3.restante", int'(bus1.restante), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
